battle_grid_state: RTL and testbench
====================================

Name: battle_grid_state

Overview:
Parametrised successor to the fixed 10x10 game-state block. Holds per-cell shot status for an ROWS x COLS board against a compile-time ship map, consumes fire requests at the cursor cell, and counts turns and hits. Drives win/lose flags and per-shot result strobes. Sits between cursor control (sprite_row/sprite_col) and the renderer/SSD controller in the VGA top level. New behaviour: configurable board size, turn budget and ship layout; duplicate-shot rejection; new_game restart without reset; shot result strobes.

Parameters:
ROWS, 10, board rows (1..16)
COLS, 10, board columns (1..16)
MAX_TURNS, 20, turn budget loaded at reset/new game (1..2**TURN_W-1)
TURN_W, 5, width of turns_left
SHIP_MAP, 100-bit constant, ship present bit per cell, index = row*COLS+col
SHIP_CELLS, 17, number of set bits in SHIP_MAP (elaboration check must match popcount)
DEBOUNCE_CYCLES, 1000000, stable-high cycles required on btn_c (BGS_DEBOUNCE_EN only)

Ports:
clk  in  1  system clock (100 MHz)
reset_n  in  1  asynchronous active-low reset
btn_c  in  1  raw fire button, asynchronous to clk
new_game  in  1  synchronous single-cycle restart request
sprite_row  in  $clog2(ROWS)  cursor row
sprite_col  in  $clog2(COLS)  cursor column
cell_status_flat  out  2*ROWS*COLS  2 bits per cell, cell i at [2i+1:2i]
turns_left  out  TURN_W  remaining turns
hits  out  $clog2(SHIP_CELLS+1)  ship cells hit so far
shot_done  out  1  one-cycle strobe: a shot was accepted
shot_hit  out  1  valid with shot_done: 1 = hit, 0 = miss
win  out  1  level, all ship cells hit
lose  out  1  level, turns exhausted without win

Behaviour:
- Cell codes (shared package): UNKNOWN=2'b00, MISS=2'b01, HIT=2'b10, 2'b11 reserved, never written.
- Reset (reset_n low, asynchronous): all cells UNKNOWN, turns_left=MAX_TURNS, hits=0, shot_done=shot_hit=win=lose=0, FSM=PLAY, sync/edge flops 0.
- btn_c passes through a 2-flop synchroniser, then a rising-edge detector yields fire (one cycle per press). Held button gives one fire.
- FSM states: PLAY, RESOLVE, WIN, LOSE.
- PLAY + fire: shot accepted only if cursor in range (row<ROWS, col<COLS) and cell==UNKNOWN. On the accepting edge: cell<=HIT if SHIP_MAP bit set else MISS; turns_left decrements by 1; hits increments on hit; shot_done=1 and shot_hit valid for exactly that next cycle; FSM->RESOLVE.
- Rejected fire (out of range or cell already MISS/HIT): no state change, no strobe, no turn consumed.
- RESOLVE (one cycle): hits==SHIP_CELLS -> WIN (win=1); else turns_left==0 -> LOSE (lose=1); else PLAY. Win has priority when the last turn sinks the last ship cell. fire in RESOLVE is dropped.
- Latency: btn_c high sampled at edge N -> cell/turns/hits update at edge N+3 -> win/lose at edge N+4.
- WIN/LOSE: absorbing; fire ignored; outputs hold.
- new_game (any state, highest priority over fire): next edge restores reset values synchronously. Simultaneous fire and new_game: new_game wins, the shot is discarded.
- turns_left never wraps; hits never exceeds SHIP_CELLS.

Optional Feature:
BGS_DEBOUNCE_EN. Defined: a counter after the synchroniser requires DEBOUNCE_CYCLES consecutive equal samples before the debounced level changes. Edge detection runs on the debounced level, and latency grows by DEBOUNCE_CYCLES. Undefined: no counter, so the edge detector sees the synchronised level directly. The latency stated above applies.

Decomposition:
- Package battle_pkg: cell code constants, FSM state encoding, cell index function row*COLS+col.
- Sub-module btn_pulse: synchroniser, optional debounce and rising-edge detector with clk/reset_n, level in, one-cycle pulse out. Reusable for the BtnL/R/U/D cursor buttons.

Test Plan:
- Reset mid-game after 3 shots -> all 200 status bits 0, turns_left=20, hits=0, win=lose=0 immediately (asynchronous).
- Fire at (0,0) with ship bit 1 -> cell[1:0]=HIT, turns_left 20->19, hits=1, shot_done/shot_hit pulse 1 cycle at edge N+3.
- Fire twice at the same miss cell -> second press gives no strobe and turns_left unchanged. Holding btn_c for 50 cycles gives only one shot.
- Fire at 17 ship cells within 20 turns -> win=1 one cycle after the 17th shot. Further presses leave all outputs unchanged.
- Fire at 20 water cells -> lose=1 and turns_left=0. new_game then restores turns_left=20 with all cells UNKNOWN. With ROWS=4, COLS=4, a last-turn final hit -> win=1, lose=0.
- Cursor at row 12 on a 10-row board -> fire ignored. With BGS_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a 5-cycle glitch gives no shot and a 10-cycle press gives one shot.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared cell codes, FSM encoding and board helpers for the battleship game state.
package battle_pkg;

  localparam logic [1:0] CELL_UNKNOWN = 2'b00;
  localparam logic [1:0] CELL_MISS    = 2'b01;
  localparam logic [1:0] CELL_HIT     = 2'b10;

  localparam int unsigned MAX_CELLS = 256;

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_RESOLVE,
    ST_WIN,
    ST_LOSE
  } state_e;

  function automatic int unsigned cell_index(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
    return row * cols + col;
  endfunction

  function automatic int unsigned popcount_map(input logic [MAX_CELLS-1:0] map);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_CELLS; i++) n += 32'(map[i]);
    return n;
  endfunction

endpackage

// File: rtl/battle_grid_state_btn_pulse.sv
// Button conditioner: 2-flop synchroniser, optional debounce (BGS_DEBOUNCE_EN),
// registered rising-edge pulse.
module btn_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic sync0_q;
  logic sync1_q;
  logic prev_q;
  logic stable;

  if (DEBOUNCE_CYCLES == 0) begin : g_cycles_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= level;
      sync1_q <= sync0_q;
    end
  end

`ifdef BGS_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             db_q;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (sync1_q == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q <= '0;
      db_q  <= sync1_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stable = db_q;
`else
  assign stable = sync1_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      prev_q <= stable;
      pulse  <= stable & ~prev_q;
    end
  end

endmodule

// File: rtl/battle_grid_state.sv
// Battleship game state: per-cell shot status, turn/hit counters, win/lose flags.
// Optional fire-button debounce enabled by defining BGS_DEBOUNCE_EN.
module battle_grid_state
  import battle_pkg::*;
#(
  parameter int unsigned ROWS            = 10,
  parameter int unsigned COLS            = 10,
  parameter int unsigned MAX_TURNS       = 20,
  parameter int unsigned TURN_W          = 5,
  parameter int unsigned SHIP_CELLS      = 17,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [ROWS*COLS-1:0] SHIP_MAP = 100'h0_0003_0000_7000_0700_00F0_001F,
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned HITS_W = (SHIP_CELLS > 0) ? $clog2(SHIP_CELLS + 1) : 1,
  localparam int unsigned NCELLS = ROWS * COLS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_c,
  input  logic                new_game,
  input  logic [ROW_W-1:0]    sprite_row,
  input  logic [COL_W-1:0]    sprite_col,
  output logic [2*NCELLS-1:0] cell_status_flat,
  output logic [TURN_W-1:0]   turns_left,
  output logic [HITS_W-1:0]   hits,
  output logic                shot_done,
  output logic                shot_hit,
  output logic                win,
  output logic                lose
);

  localparam int unsigned IDX_W = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic [TURN_W-1:0] TURNS_INIT = TURN_W'(MAX_TURNS);
  localparam logic [HITS_W-1:0] HITS_ALL   = HITS_W'(SHIP_CELLS);

  if (popcount_map(MAX_CELLS'(SHIP_MAP)) != SHIP_CELLS) begin : g_ship_cells_check
    $error("SHIP_CELLS does not match the number of ship bits in SHIP_MAP");
  end

  state_e             state_q, state_d;
  logic [1:0]         cell_q [NCELLS];
  logic [1:0]         cell_d [NCELLS];
  logic [TURN_W-1:0]  turns_d;
  logic [HITS_W-1:0]  hits_d;
  logic               shot_done_d;
  logic               shot_hit_d;
  logic               fire;
  logic               in_range;
  logic               is_ship;
  logic [IDX_W-1:0]   shot_idx;

  btn_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_fire (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (btn_c),
    .pulse  (fire)
  );

  // Out-of-range cursors are forced to index 0 and never accepted.
  assign in_range = (32'(sprite_row) < ROWS) && (32'(sprite_col) < COLS);
  assign shot_idx = in_range ? IDX_W'(cell_index(32'(sprite_row), 32'(sprite_col), COLS)) : '0;
  assign is_ship  = SHIP_MAP[shot_idx];

  always_comb begin
    state_d     = state_q;
    cell_d      = cell_q;
    turns_d     = turns_left;
    hits_d      = hits;
    shot_done_d = 1'b0;
    shot_hit_d  = 1'b0;
    if (new_game) begin
      state_d = ST_PLAY;
      for (int unsigned i = 0; i < NCELLS; i++) cell_d[i] = CELL_UNKNOWN;
      turns_d = TURNS_INIT;
      hits_d  = '0;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          if (fire && in_range && (cell_q[shot_idx] == CELL_UNKNOWN) && (turns_left != '0)) begin
            cell_d[shot_idx] = is_ship ? CELL_HIT : CELL_MISS;
            turns_d          = turns_left - TURN_W'(1);
            if (is_ship) hits_d = hits + HITS_W'(1);
            shot_done_d      = 1'b1;
            shot_hit_d       = is_ship;
            state_d          = ST_RESOLVE;
          end
        end
        // A last-turn sinking shot counts as a win.
        ST_RESOLVE: begin
          if (hits == HITS_ALL)         state_d = ST_WIN;
          else if (turns_left == '0)    state_d = ST_LOSE;
          else                          state_d = ST_PLAY;
        end
        ST_WIN:  state_d = ST_WIN;
        ST_LOSE: state_d = ST_LOSE;
        default: state_d = ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_PLAY;
      for (int unsigned i = 0; i < NCELLS; i++) cell_q[i] <= CELL_UNKNOWN;
      turns_left <= TURNS_INIT;
      hits       <= '0;
      shot_done  <= 1'b0;
      shot_hit   <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cell_q     <= cell_d;
      turns_left <= turns_d;
      hits       <= hits_d;
      shot_done  <= shot_done_d;
      shot_hit   <= shot_hit_d;
      win        <= (state_d == ST_WIN);
      lose       <= (state_d == ST_LOSE);
    end
  end

  for (genvar i = 0; i < NCELLS; i++) begin : g_flat
    assign cell_status_flat[2*i +: 2] = cell_q[i];
  end

endmodule

// File: tb/tb_battle_grid_state.sv
// Directed self-checking bench for battle_grid_state (default 10x10 board plus a 4x4 board).
`timescale 1ns/1ps
module tb_battle_grid_state;

  localparam int DB = 8;
`ifdef BGS_DEBOUNCE_EN
  localparam int LAT  = 4 + DB;
  localparam int HOLD = DB + 4;
`else
  localparam int LAT  = 4;
  localparam int HOLD = 3;
`endif
  localparam int SETTLE = 2 * DB + 6;

  localparam int SHIP_R [17] = '{0,0,0,0,0,2,2,2,2,4,4,4,6,6,6,8,8};
  localparam int SHIP_C [17] = '{0,1,2,3,4,0,1,2,3,0,1,2,0,1,2,0,1};

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic         btn_a = 1'b0, new_game_a = 1'b0;
  logic [3:0]   row_a = '0, col_a = '0;
  logic [199:0] flat_a;
  logic [4:0]   turns_a, hits_a;
  logic         done_a, hit_a, win_a, lose_a;

  logic         btn_b = 1'b0, new_game_b = 1'b0;
  logic [1:0]   row_b = '0, col_b = '0;
  logic [31:0]  flat_b;
  logic [4:0]   turns_b;
  logic [1:0]   hits_b;
  logic         done_b, hit_b, win_b, lose_b;

  int checks = 0;
  int failures = 0;
  int strobes_a = 0;
  int strobes_b = 0;
  logic last_hit_a = 1'b0;

  always #5 clk = ~clk;

  battle_grid_state #(.DEBOUNCE_CYCLES(DB)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .btn_c(btn_a), .new_game(new_game_a),
    .sprite_row(row_a), .sprite_col(col_a), .cell_status_flat(flat_a),
    .turns_left(turns_a), .hits(hits_a), .shot_done(done_a), .shot_hit(hit_a),
    .win(win_a), .lose(lose_a)
  );

  battle_grid_state #(
    .ROWS(4), .COLS(4), .MAX_TURNS(3), .TURN_W(5), .SHIP_CELLS(2),
    .SHIP_MAP(16'h0003), .DEBOUNCE_CYCLES(DB)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .btn_c(btn_b), .new_game(new_game_b),
    .sprite_row(row_b), .sprite_col(col_b), .cell_status_flat(flat_b),
    .turns_left(turns_b), .hits(hits_b), .shot_done(done_b), .shot_hit(hit_b),
    .win(win_b), .lose(lose_b)
  );

  always @(negedge clk) begin
    if (done_a) begin
      strobes_a++;
      last_hit_a = hit_a;
    end
    if (done_b) strobes_b++;
  end

  task automatic press(input bit on_b, input int r, input int c, input int hold);
    if (on_b) begin row_b = 2'(r); col_b = 2'(c); end
    else      begin row_a = 4'(r); col_a = 4'(c); end
    @(negedge clk);
    if (on_b) btn_b = 1'b1; else btn_a = 1'b1;
    repeat (hold) @(negedge clk);
    btn_a = 1'b0;
    btn_b = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic pulse_new_game_a();
    @(negedge clk); new_game_a = 1'b1;
    @(negedge clk); new_game_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (flat_a !== '0) begin failures++; $display("FAIL reset_cells got=%0h want=0", flat_a); end
    checks++; if (turns_a !== 5'd20) begin failures++; $display("FAIL reset_turns got=%0d want=20", turns_a); end
    checks++; if ({hits_a, win_a, lose_a, done_a, hit_a} !== '0) begin failures++; $display("FAIL reset_flags got hits=%0d win=%b lose=%b done=%b hit=%b want all 0", hits_a, win_a, lose_a, done_a, hit_a); end
    checks++; if (flat_b !== '0 || turns_b !== 5'd3) begin failures++; $display("FAIL reset_small got cells=%0h turns=%0d want 0 and 3", flat_b, turns_b); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_hit();
    int k;
    bit seen;
    row_a = 4'd0; col_a = 4'd0;
    @(negedge clk);
    btn_a = 1'b1;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || k != LAT) begin failures++; $display("FAIL hit_latency got=%0d seen=%b want=%0d", k, seen, LAT); end
    checks++; if (hit_a !== 1'b1) begin failures++; $display("FAIL hit_strobe got=%b want=1", hit_a); end
    checks++; if (flat_a[1:0] !== 2'b10) begin failures++; $display("FAIL hit_cell got=%b want=10", flat_a[1:0]); end
    checks++; if (turns_a !== 5'd19 || hits_a !== 5'd1) begin failures++; $display("FAIL hit_counts got turns=%0d hits=%0d want 19 1", turns_a, hits_a); end
    @(negedge clk);
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL hit_pulse_width got=%b want=0", done_a); end
    btn_a = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic test_duplicate_and_hold();
    int s0;
    s0 = strobes_a;
    press(1'b0, 9, 9, HOLD);
    checks++; if (strobes_a != s0 + 1 || last_hit_a !== 1'b0) begin failures++; $display("FAIL miss_strobe got n=%0d hit=%b want n=%0d hit=0", strobes_a, last_hit_a, s0 + 1); end
    checks++; if (flat_a[199:198] !== 2'b01 || turns_a !== 5'd18) begin failures++; $display("FAIL miss_cell got cell=%b turns=%0d want 01 18", flat_a[199:198], turns_a); end
    press(1'b0, 9, 9, HOLD);
    checks++; if (strobes_a != s0 + 1 || turns_a !== 5'd18) begin failures++; $display("FAIL duplicate got n=%0d turns=%0d want n=%0d turns=18", strobes_a, turns_a, s0 + 1); end
    press(1'b0, 9, 8, 50);
    checks++; if (strobes_a != s0 + 2 || turns_a !== 5'd17 || flat_a[197:196] !== 2'b01) begin failures++; $display("FAIL held_button got n=%0d turns=%0d cell=%b want n=%0d 17 01", strobes_a, turns_a, flat_a[197:196], s0 + 2); end
  endtask

  task automatic test_out_of_range();
    int s0;
    s0 = strobes_a;
    press(1'b0, 12, 0, HOLD);
    press(1'b0, 0, 10, HOLD);
    checks++; if (strobes_a != s0 || turns_a !== 5'd17 || hits_a !== 5'd1) begin failures++; $display("FAIL out_of_range got n=%0d turns=%0d hits=%0d want n=%0d 17 1", strobes_a, turns_a, hits_a, s0); end
  endtask

  task automatic test_reset_mid_game();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (flat_a !== '0 || turns_a !== 5'd20 || hits_a !== 5'd0 || win_a !== 1'b0 || lose_a !== 1'b0) begin failures++; $display("FAIL async_reset got cells=%0h turns=%0d hits=%0d win=%b lose=%b", flat_a, turns_a, hits_a, win_a, lose_a); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_win();
    int k;
    bit seen;
    int s0;
    logic [199:0] snap;
    for (int i = 0; i < 16; i++) press(1'b0, SHIP_R[i], SHIP_C[i], HOLD);
    checks++; if (hits_a !== 5'd16 || win_a !== 1'b0) begin failures++; $display("FAIL pre_win got hits=%0d win=%b want 16 0", hits_a, win_a); end
    row_a = 4'(SHIP_R[16]); col_a = 4'(SHIP_C[16]);
    @(negedge clk);
    btn_a = 1'b1;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || win_a !== 1'b0) begin failures++; $display("FAIL win_early got seen=%b win=%b want 1 0", seen, win_a); end
    @(negedge clk);
    checks++; if (win_a !== 1'b1 || lose_a !== 1'b0 || hits_a !== 5'd17 || turns_a !== 5'd3) begin failures++; $display("FAIL win got win=%b lose=%b hits=%0d turns=%0d want 1 0 17 3", win_a, lose_a, hits_a, turns_a); end
    btn_a = 1'b0;
    repeat (SETTLE) @(negedge clk);
    snap = flat_a;
    s0 = strobes_a;
    press(1'b0, 9, 0, HOLD);
    press(1'b0, 5, 5, HOLD);
    checks++; if (flat_a !== snap || strobes_a != s0 || turns_a !== 5'd3 || win_a !== 1'b1) begin failures++; $display("FAIL win_absorbing got n=%0d turns=%0d win=%b want n=%0d 3 1", strobes_a, turns_a, win_a, s0); end
  endtask

  task automatic test_lose_and_new_game();
    int s0;
    pulse_new_game_a();
    checks++; if (flat_a !== '0 || turns_a !== 5'd20 || win_a !== 1'b0 || hits_a !== 5'd0) begin failures++; $display("FAIL new_game_after_win got turns=%0d win=%b hits=%0d", turns_a, win_a, hits_a); end
    for (int i = 0; i < 20; i++) press(1'b0, (i < 10) ? 9 : 7, i % 10, HOLD);
    checks++; if (lose_a !== 1'b1 || win_a !== 1'b0 || turns_a !== 5'd0 || hits_a !== 5'd0) begin failures++; $display("FAIL lose got lose=%b win=%b turns=%0d hits=%0d want 1 0 0 0", lose_a, win_a, turns_a, hits_a); end
    s0 = strobes_a;
    press(1'b0, 5, 5, HOLD);
    checks++; if (strobes_a != s0 || turns_a !== 5'd0 || lose_a !== 1'b1) begin failures++; $display("FAIL lose_absorbing got n=%0d turns=%0d lose=%b", strobes_a, turns_a, lose_a); end
    pulse_new_game_a();
    checks++; if (flat_a !== '0 || turns_a !== 5'd20 || lose_a !== 1'b0) begin failures++; $display("FAIL new_game_after_lose got cells=%0h turns=%0d lose=%b want 0 20 0", flat_a, turns_a, lose_a); end
  endtask

  task automatic test_new_game_beats_fire();
    int s0;
    press(1'b0, 9, 0, HOLD);
    checks++; if (turns_a !== 5'd19) begin failures++; $display("FAIL pre_collision got turns=%0d want 19", turns_a); end
    s0 = strobes_a;
    row_a = 4'd0; col_a = 4'd0;
    @(negedge clk);
    btn_a = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    new_game_a = 1'b1;
    @(negedge clk);
    new_game_a = 1'b0;
    repeat (HOLD) @(negedge clk);
    btn_a = 1'b0;
    repeat (SETTLE) @(negedge clk);
    checks++; if (strobes_a != s0 || turns_a !== 5'd20 || flat_a !== '0 || hits_a !== 5'd0) begin failures++; $display("FAIL collision got n=%0d turns=%0d hits=%0d want n=%0d 20 0", strobes_a, turns_a, hits_a, s0); end
  endtask

  task automatic test_small_board();
    press(1'b1, 3, 3, HOLD);
    press(1'b1, 0, 0, HOLD);
    checks++; if (turns_b !== 5'd1 || hits_b !== 2'd1 || win_b !== 1'b0) begin failures++; $display("FAIL small_mid got turns=%0d hits=%0d win=%b want 1 1 0", turns_b, hits_b, win_b); end
    press(1'b1, 0, 1, HOLD);
    checks++; if (win_b !== 1'b1 || lose_b !== 1'b0 || turns_b !== 5'd0 || hits_b !== 2'd2) begin failures++; $display("FAIL small_last_turn_win got win=%b lose=%b turns=%0d hits=%0d want 1 0 0 2", win_b, lose_b, turns_b, hits_b); end
    checks++; if (flat_b[31:30] !== 2'b01 || flat_b[3:0] !== 4'b1010 || strobes_b != 3) begin failures++; $display("FAIL small_cells got hi=%b lo=%b n=%0d want 01 1010 3", flat_b[31:30], flat_b[3:0], strobes_b); end
  endtask

`ifdef BGS_DEBOUNCE_EN
  task automatic test_debounce();
    int s0;
    pulse_new_game_a();
    s0 = strobes_a;
    press(1'b0, 0, 0, 5);
    checks++; if (strobes_a != s0 || turns_a !== 5'd20) begin failures++; $display("FAIL glitch got n=%0d turns=%0d want n=%0d 20", strobes_a, turns_a, s0); end
    press(1'b0, 0, 0, 10);
    checks++; if (strobes_a != s0 + 1 || turns_a !== 5'd19) begin failures++; $display("FAIL debounced_press got n=%0d turns=%0d want n=%0d 19", strobes_a, turns_a, s0 + 1); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_hit();
    test_duplicate_and_hold();
    test_out_of_range();
    test_reset_mid_game();
    test_win();
    test_lose_and_new_game();
    test_new_game_beats_fire();
    test_small_board();
`ifdef BGS_DEBOUNCE_EN
    test_debounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
